// File: rtl/width_pkg.sv
// Shared access-width encoding, funct3 constants and sequencing states
// for the load/store alignment unit.
package width_pkg;

  typedef enum logic [1:0] {
    W_WORD   = 2'b00,
    W_BYTE   = 2'b01,
    W_HALF   = 2'b10,
    W_DOUBLE = 2'b11
  } width_e;

  // WidthSrc: [2] = unsigned, [1:0] = width_e
  typedef struct packed {
    logic   is_unsigned;
    width_e width;
  } width_src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic width_src_t decode_funct3(input logic [2:0] f3);
    width_src_t src;
    src.is_unsigned = f3[2];
    case (f3[1:0])
      2'b00:   src.width = W_BYTE;
      2'b01:   src.width = W_HALF;
      2'b10:   src.width = W_WORD;
      default: src.width = W_DOUBLE;
    endcase
    return src;
  endfunction

  function automatic logic [3:0] width_bytes(input width_e w);
    logic [3:0] n;
    case (w)
      W_BYTE:  n = 4'd1;
      W_HALF:  n = 4'd2;
      W_WORD:  n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lane_extender.sv
// Shifts a (possibly two-beat) bus window down to the access offset and
// sign/zero-extends the selected bytes to XLEN.
module lane_extender
  import width_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]         raw,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  width_e                    width,
  input  logic                      is_unsigned,
  output logic [XLEN-1:0]           data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            msb;

  assign shifted = XLEN'(raw >> {offset, 3'b000});

  always_comb begin
    mask = '1;
    msb  = shifted[XLEN-1];
    case (width)
      W_BYTE: begin
        mask = XLEN'(8'hFF);
        msb  = shifted[7];
      end
      W_HALF: begin
        mask = XLEN'(16'hFFFF);
        msb  = shifted[15];
      end
      W_WORD: begin
        mask = XLEN'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        mask = '1;
        msb  = shifted[XLEN-1];
      end
    endcase
    data = (shifted & mask) | ((msb && !is_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/misaligned_lsu_aligner.sv
// Load/store alignment unit: funct3 width decode, bus-word beats with lane
// enables, store lane steering and split handling of boundary-crossing accesses.
module misaligned_lsu_aligner
  import width_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   Addr,
  input  logic [XLEN-1:0]   WriteData,
  output logic              MemReq,
  output logic              MemWe,
  output logic [XLEN-1:0]   MemAddr,
  output logic [XLEN/8-1:0] MemByteEn,
  output logic [XLEN-1:0]   MemWData,
  input  logic [XLEN-1:0]   MemRData,
  input  logic              MemReady,
  output logic              RespValid,
  output logic [XLEN-1:0]   RespData,
  output logic              Fault
);

  localparam int NB  = XLEN / 8;
  localparam int NB2 = 2 * NB;
  localparam int OB  = $clog2(NB);

  state_e            state_reg, state_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [XLEN-1:0]   mem_addr_reg, mem_addr_next;
  logic [NB-1:0]     mem_be_reg, mem_be_next;
  logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0]   resp_data_reg, resp_data_next;
  logic              fault_reg, fault_next;

  logic              write_reg, write_next;
  width_e            width_reg, width_next;
  logic              uns_reg, uns_next;
  logic [OB-1:0]     off_reg, off_next;
  logic              cross_reg, cross_next;
  logic [NB-1:0]     be1_reg, be1_next;
  logic [XLEN-1:0]   wdata1_reg, wdata1_next;
  logic [XLEN-1:0]   lo_reg, lo_next;

  width_src_t        req_src;
  logic [3:0]        req_size;
  logic [OB-1:0]     req_off;
  logic [XLEN-1:0]   req_floor;
  logic              req_legal, req_cross, req_misaligned;
  logic [NB2-1:0]    be_wide;
  logic [2*XLEN-1:0] wide_data, steer_data;
  logic [2*XLEN-1:0] raw;
  logic [XLEN-1:0]   ext_data;

  assign req_src        = decode_funct3(funct3);
  assign req_size       = width_bytes(req_src.width);
  assign req_off        = Addr[OB-1:0];
  assign req_floor      = {Addr[XLEN-1:OB], {OB{1'b0}}};
  assign req_cross      = (5'(req_off) + 5'(req_size)) > 5'(NB);
  assign req_misaligned = (4'(req_off) & (req_size - 4'd1)) != 4'd0;

  always_comb begin
    req_legal = 1'b0;
    if (ReqWrite) begin
      case (funct3)
        F3_B, F3_H, F3_W: req_legal = 1'b1;
        F3_D:             req_legal = (XLEN == 64);
        default:          req_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: req_legal = 1'b1;
        F3_D, F3_WU:                    req_legal = (XLEN == 64);
        default:                        req_legal = 1'b0;
      endcase
    end
  end

  // Lanes over a double-word window: the low half is beat0, the high half beat1.
  assign be_wide   = ((NB2'(1) << req_size) - NB2'(1)) << req_off;
  assign wide_data = {{XLEN{1'b0}}, WriteData} << {req_off, 3'b000};

  genvar gi;
  for (gi = 0; gi < NB2; gi++) begin : g_lane
    assign steer_data[gi*8 +: 8] = (ReqWrite && be_wide[gi]) ? wide_data[gi*8 +: 8] : 8'h00;
  end

  assign raw = (state_reg == BEAT1) ? {MemRData, lo_reg} : {{XLEN{1'b0}}, MemRData};

  lane_extender #(.XLEN(XLEN)) u_lane_extender (
    .raw         (raw),
    .offset      (off_reg),
    .width       (width_reg),
    .is_unsigned (uns_reg),
    .data        (ext_data)
  );

  always_comb begin
    state_next      = state_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_be_next     = mem_be_reg;
    mem_wdata_next  = mem_wdata_reg;
    resp_valid_next = 1'b0;
    resp_data_next  = resp_data_reg;
    fault_next      = 1'b0;
    write_next      = write_reg;
    width_next      = width_reg;
    uns_next        = uns_reg;
    off_next        = off_reg;
    cross_next      = cross_reg;
    be1_next        = be1_reg;
    wdata1_next     = wdata1_reg;
    lo_next         = lo_reg;
    case (state_reg)
      IDLE: begin
        if (ReqValid) begin
          write_next = ReqWrite;
          width_next = req_src.width;
          uns_next   = req_src.is_unsigned;
          off_next   = req_off;
          cross_next = req_cross;
          if (!req_legal || (!ALLOW_MISALIGNED && req_misaligned)) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            fault_next      = 1'b1;
            resp_data_next  = '0;
          end else begin
            state_next     = BEAT0;
            mem_req_next   = 1'b1;
            mem_we_next    = ReqWrite;
            mem_addr_next  = req_floor;
            mem_be_next    = be_wide[NB-1:0];
            mem_wdata_next = steer_data[XLEN-1:0];
            be1_next       = be_wide[NB2-1:NB];
            wdata1_next    = steer_data[2*XLEN-1:XLEN];
          end
        end
      end
      BEAT0: begin
        if (MemReady) begin
          if (cross_reg) begin
            state_next     = BEAT1;
            mem_addr_next  = mem_addr_reg + XLEN'(NB);
            mem_be_next    = be1_reg;
            mem_wdata_next = wdata1_reg;
            lo_next        = MemRData;
          end else begin
            state_next      = RESP;
            mem_req_next    = 1'b0;
            resp_valid_next = 1'b1;
            resp_data_next  = write_reg ? '0 : ext_data;
          end
        end
      end
      BEAT1: begin
        if (MemReady) begin
          state_next      = RESP;
          mem_req_next    = 1'b0;
          resp_valid_next = 1'b1;
          resp_data_next  = write_reg ? '0 : ext_data;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_be_reg     <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      fault_reg      <= 1'b0;
      write_reg      <= 1'b0;
      width_reg      <= W_WORD;
      uns_reg        <= 1'b0;
      off_reg        <= '0;
      cross_reg      <= 1'b0;
      be1_reg        <= '0;
      wdata1_reg     <= '0;
      lo_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_be_reg     <= mem_be_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
      fault_reg      <= fault_next;
      write_reg      <= write_next;
      width_reg      <= width_next;
      uns_reg        <= uns_next;
      off_reg        <= off_next;
      cross_reg      <= cross_next;
      be1_reg        <= be1_next;
      wdata1_reg     <= wdata1_next;
      lo_reg         <= lo_next;
    end
  end

  assign ReqReady  = (state_reg == IDLE);
  assign MemReq    = mem_req_reg;
  assign MemWe     = mem_we_reg;
  assign MemAddr   = mem_addr_reg;
  assign MemByteEn = mem_be_reg;
  assign MemWData  = mem_wdata_reg;
  assign RespValid = resp_valid_reg;
  assign RespData  = resp_data_reg;
  assign Fault     = fault_reg;

endmodule
